// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides; optional macro BOOTH_EARLY_TERM_EN
//   clk, rst (async active-high); in_valid/in_ready, x, y (signed WIDTH); out_valid/out_ready, product (signed 2*WIDTH); busy (RUN state)
module booth_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next_state;
  logic [PW-1:0] x_sh, acc, mag, pp;
  logic [WIDTH:0] y_sh;
  logic [CW-1:0] cnt;
  logic [2:0] d;
  logic last, zero_rest;
  // x_sh carries x pre-shifted to the current digit weight; y_sh shifts the
  // multiplier right (sign-filling) so the current digit is always y_sh[2:0]
  always_comb begin
    d = y_sh[2:0];
    mag = (d == 3'b000 || d == 3'b111) ? '0 : (d == 3'b011 || d == 3'b100) ? x_sh << 1 : x_sh;
    pp = d[2] ? -mag : mag;
    last = cnt == CW'(N - 1);
`ifdef BOOTH_EARLY_TERM_EN
    zero_rest = (y_sh == '0) || (y_sh == '1);
`else
    zero_rest = 1'b0;
`endif
    next_state = (state == IDLE && in_valid) ? RUN :
                 (state == RUN && (zero_rest || last)) ? DONE :
                 (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sh <= '0;
      y_sh <= '0;
      acc <= '0;
      cnt <= '0;
      product <= '0;
    end else if (state == IDLE && in_valid) begin
      x_sh <= {{WIDTH{x[WIDTH-1]}}, x};
      y_sh <= {y, 1'b0};
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      if (zero_rest) product <= acc;
      else begin
        acc <= acc + pp;
        x_sh <= x_sh << 2;
        y_sh <= {{2{y_sh[WIDTH]}}, y_sh[WIDTH:2]};
        cnt <= cnt + 1'b1;
        if (last) product <= acc + pp;
      end
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state == RUN;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: randomized and directed self-checking bench against an arithmetic reference model
module tb_booth_seq_multiplier;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic [7:0] x = 0, y = 0;
  logic in_ready, out_valid, busy;
  logic [15:0] product;
  int n_checks = 0, n_fail = 0;
  booth_seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    p = sa * sb;
    return p[15:0];
  endfunction
  // cycles from accept to out_valid: with early termination, the first digit
  // index from which every remaining multiplier bit (incl. y_-1=0) is equal
  function automatic int exp_lat(input logic [7:0] b);
`ifdef BOOTH_EARLY_TERM_EN
    int e;
    e = $signed(b) * 2;
    for (int i = 0; i < 4; i++)
      if ((e >>> (2 * i)) == 0 || (e >>> (2 * i)) == -1) return i + 1;
`endif
    return 4;
  endfunction
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    x = a;
    y = b;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    check({tag, "_busy"}, {in_ready, busy}, 2'b01);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_lat"}, lat, exp_lat(b));
    check({tag, "_prod"}, product, ref_prod(a, b));
  endtask
  task automatic handshake(input string tag);
    out_ready = 1;
    @(posedge clk);
    #1 check({tag, "_release"}, {out_valid, in_ready, busy}, 3'b010);
  endtask
  initial begin
    logic [15:0] held;
    logic [15:0] q[$];
    int acc_n, res_n;
    #1 rst = 1;
    #2 check("reset", {in_ready, out_valid, busy, product}, {3'b100, 16'h0});
    @(negedge clk) rst = 0;
    run_op(8'd7, 8'hFD, "basic");
    check("basic_val", product, 16'hFFEB);
    handshake("basic");
    run_op(8'h80, 8'h80, "mn_mn");
    check("mn_mn_val", product, 16'h4000);
    handshake("mn_mn");
    run_op(8'h7F, 8'h80, "mx_mn");
    check("mx_mn_val", product, 16'hC080);
    handshake("mx_mn");
    run_op(8'h00, 8'hFF, "zero");
    handshake("zero");
    run_op(8'hFF, 8'hFF, "m1_m1");
    check("m1_m1_val", product, 16'h0001);
    handshake("m1_m1");
    run_op(8'd5, 8'd1, "et_5_1");
    handshake("et_5_1");
    run_op(8'd9, 8'd0, "et_9_0");
    handshake("et_9_0");
    run_op(8'd3, 8'h80, "et_mn");
    handshake("et_mn");
    out_ready = 0;
    run_op(8'd11, 8'hF3, "bp");
    held = product;
    x = 8'd2;
    y = 8'd2;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      @(posedge clk);
      #1 check("bp_hold", {out_valid, in_ready, product}, {2'b10, held});
    end
    in_valid = 0;
    handshake("bp");
    check("bp_after", product, held);
    run_op(8'hC4, 8'd37, "bp_next");
    handshake("bp_next");
    run_op(8'd100, 8'd50, "abort_start");
    handshake("abort_start");
    @(negedge clk);
    x = 8'd100;
    y = 8'd50;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    #1 check("abort", {in_ready, out_valid, busy, product}, {3'b100, 16'h0});
    @(negedge clk) rst = 0;
    run_op(8'd3, 8'd4, "post_rst");
    check("post_rst_val", product, 16'h000C);
    handshake("post_rst");
    acc_n = 0;
    res_n = 0;
    out_ready = 1;
    x = 8'($urandom);
    y = 8'($urandom);
    in_valid = 1;
    for (int c = 0; c < 5000 && res_n < 200; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) check("b2b_extra", 1, 0);
        else check("b2b_prod", product, q.pop_front());
        res_n++;
      end
      if (in_ready && in_valid) begin
        q.push_back(ref_prod(x, y));
        acc_n++;
        @(posedge clk);
        #1 x = 8'($urandom);
        y = 8'($urandom);
        if (acc_n == 200) in_valid = 0;
      end
    end
    in_valid = 0;
    check("b2b_accepted", acc_n, 200);
    check("b2b_results", res_n, 200);
    check("b2b_pending", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
